// File: rtl/bip_debug_controller.sv
// Host command sequencer for the BIP core: gates the CPU clock enable for RUN/STEP,
// pulses a soft reset on CLR, and streams a 6-byte PC/ACC/CNT report over the UART.
module bip_debug_controller #(
    parameter int PC_W   = 11,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_done,
    input  logic              cpu_halt,
    input  logic [PC_W-1:0]   cpu_pc,
    input  logic [DATA_W-1:0] cpu_acc,
    output logic              cpu_enable,
    output logic              cpu_rst,
    output logic              busy
);

    localparam logic [7:0] CMD_RUN  = 8'h01;
    localparam logic [7:0] CMD_STEP = 8'h02;
    localparam logic [7:0] CMD_CLR  = 8'h03;
    localparam logic [2:0] LAST_IDX = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_CLR,
        S_SNAP,
        S_SEND,
        S_WAIT_TX
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_halted;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_idx;
    logic [15:0]        r_rep_pc;
    logic [15:0]        r_rep_acc;
    logic [15:0]        r_rep_cnt;
    logic               w_enable;

    assign w_enable   = ((r_state == S_RUN) || (r_state == S_STEP)) && !cpu_halt && !r_halted;
    assign cpu_enable = w_enable;
    assign cpu_rst    = (r_state == S_CLR);
    assign tx_start   = (r_state == S_SEND);
    assign busy       = (r_state != S_IDLE);

    // Report bytes go out most-significant first: PC, ACC, CNT.
    always_comb begin
        case (r_idx)
            3'd0:    tx_data = r_rep_pc[15:8];
            3'd1:    tx_data = r_rep_pc[7:0];
            3'd2:    tx_data = r_rep_acc[15:8];
            3'd3:    tx_data = r_rep_acc[7:0];
            3'd4:    tx_data = r_rep_cnt[15:8];
            default: tx_data = r_rep_cnt[7:0];
        endcase
    end

    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (rx_done) begin
                    case (rx_data)
                        CMD_RUN:  w_next = r_halted ? S_SNAP : S_RUN;
                        CMD_STEP: w_next = r_halted ? S_SNAP : S_STEP;
                        CMD_CLR:  w_next = S_CLR;
                        default:  w_next = S_IDLE;
                    endcase
                end
            end
            S_RUN:     if (cpu_halt) w_next = S_SNAP;
            S_STEP:    w_next = S_SNAP;
            S_CLR:     w_next = S_SNAP;
            S_SNAP:    w_next = S_SEND;
            S_SEND:    w_next = S_WAIT_TX;
            S_WAIT_TX: if (tx_done) w_next = (r_idx == LAST_IDX) ? S_IDLE : S_SEND;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_halted  <= 1'b0;
            r_cnt     <= '0;
            r_idx     <= '0;
            // NOTE: the report registers feed tx_data directly, so they are reset to give tx_data=0.
            r_rep_pc  <= '0;
            r_rep_acc <= '0;
            r_rep_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same clock edge.
            r_state <= w_next;
            case (r_state)
                S_RUN, S_STEP: begin
                    if (w_enable && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
                    if (cpu_halt) r_halted <= 1'b1;
                end
                S_CLR: begin
                    r_cnt    <= '0;
                    r_halted <= 1'b0;
                end
                S_SNAP: begin
                    r_rep_pc  <= 16'(cpu_pc);
                    r_rep_acc <= 16'(cpu_acc);
                    r_rep_cnt <= 16'(r_cnt);
                    r_idx     <= '0;
                end
                S_WAIT_TX: begin
                    if (tx_done && (r_idx != LAST_IDX)) r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
